// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/EX requesters, the memory arbiter and the memory macro.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding environment (requesters plus memory).
interface mem_arbiter_if #(
  parameter int WORD   = 32,
  parameter int W_ADDR = 32
);
  // Instruction-fetch read port
  logic              if_req;
  logic [W_ADDR-1:0] if_addr;
  logic              if_ack;
  logic [WORD-1:0]   if_rdata;

  // Execute-stage load/store port
  logic              ex_req;
  logic              ex_we;
  logic [W_ADDR-1:0] ex_addr;
  logic [WORD-1:0]   ex_wdata;
  logic              ex_ack;
  logic [WORD-1:0]   ex_rdata;

  // Memory macro port
  logic              mem_req;
  logic              mem_we;
  logic [W_ADDR-1:0] mem_addr;
  logic [WORD-1:0]   mem_wdata;
  logic [WORD-1:0]   mem_rdata;
  logic              mem_rdy;

  // Arbiter status
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  ex_req, ex_we, ex_addr, ex_wdata,
    input  mem_rdata, mem_rdy,
    output if_ack, if_rdata,
    output ex_ack, ex_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ex_req, ex_we, ex_addr, ex_wdata,
    output mem_rdata, mem_rdy,
    input  if_ack, if_rdata,
    input  ex_ack, ex_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and the execute stage
// load/store path (EX). One transaction in flight, EX has priority over IF, and a
// starvation counter forces an IF grant after STARVE_MAX contested EX grants.
// Every output is a flop or a decode of flops only; no input reaches an output
// combinationally.
module mem_arbiter #(
  parameter int WORD       = 32,
  parameter int W_ADDR     = 32,
  parameter int STARVE_MAX = 4,
  parameter int W_STARVE   = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_EX = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [W_STARVE-1:0] STARVE_LIM = W_STARVE'(STARVE_MAX);

  state_t              state_reg,      state_next;
  logic                owner_ex_reg,   owner_ex_next;   // 1 = current/last grant is EX
  logic                mem_req_reg,    mem_req_next;
  logic                mem_we_reg,     mem_we_next;
  logic [W_ADDR-1:0]   mem_addr_reg,   mem_addr_next;
  logic [WORD-1:0]     mem_wdata_reg,  mem_wdata_next;
  logic [WORD-1:0]     if_rdata_reg,   if_rdata_next;
  logic [WORD-1:0]     ex_rdata_reg,   ex_rdata_next;
  logic [W_STARVE-1:0] starve_cnt_reg, starve_cnt_next;

  logic if_blocked;

  // IF wins a contested round only once EX has taken STARVE_MAX of them in a row.
  assign if_blocked = ~(bus.if_req & (starve_cnt_reg == STARVE_LIM));

  // Next-state, bus capture and starvation bookkeeping.
  always_comb begin
    state_next      = state_reg;
    owner_ex_next   = owner_ex_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    if_rdata_next   = if_rdata_reg;
    ex_rdata_next   = ex_rdata_reg;
    starve_cnt_next = starve_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.ex_req && if_blocked) begin
          state_next     = GNT_EX;
          owner_ex_next  = 1'b1;
          mem_req_next   = 1'b1;
          mem_we_next    = bus.ex_we;
          mem_addr_next  = bus.ex_addr;
          mem_wdata_next = bus.ex_wdata;
          // Only a grant that actually made IF wait counts towards starvation.
          if (bus.if_req) begin
            if (starve_cnt_reg != STARVE_LIM) begin
              starve_cnt_next = starve_cnt_reg + 1'b1;
            end
          end else begin
            starve_cnt_next = '0;
          end
        end else if (bus.if_req) begin
          state_next      = GNT_IF;
          owner_ex_next   = 1'b0;
          mem_req_next    = 1'b1;
          mem_we_next     = 1'b0;
          mem_addr_next   = bus.if_addr;
          mem_wdata_next  = '0;
          starve_cnt_next = '0;
        end
      end

      GNT_IF: begin
        if (bus.mem_rdy) begin
          state_next    = DONE;
          mem_req_next  = 1'b0;
          if_rdata_next = bus.mem_rdata;
        end
      end

      GNT_EX: begin
        if (bus.mem_rdy) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          // Stores leave the last load result untouched.
          if (!mem_we_reg) begin
            ex_rdata_next = bus.mem_rdata;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_ex_reg   <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      if_rdata_reg   <= '0;
      ex_rdata_reg   <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_ex_reg   <= owner_ex_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      if_rdata_reg   <= if_rdata_next;
      ex_rdata_reg   <= ex_rdata_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Acks are a one-cycle decode of DONE, steered by the recorded owner.
  assign bus.if_ack    = (state_reg == DONE) & ~owner_ex_reg;
  assign bus.ex_ack    = (state_reg == DONE) &  owner_ex_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.ex_rdata  = ex_rdata_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, self-checking bench for mem_arbiter. Expected transactions are queued
// in grant order when stimulus is issued; the memory responder checks each bus
// request against the queue head, and each ack pops the queue and checks owner/data.
module tb_mem_arbiter;
  localparam int WORD   = 32;
  localparam int W_ADDR = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD(WORD), .W_ADDR(W_ADDR)) bus ();

  mem_arbiter #(
    .WORD(WORD), .W_ADDR(W_ADDR), .STARVE_MAX(4), .W_STARVE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        is_ex;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem_arr [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rsp_wait = 0;
  int          rsp_cnt  = 0;
  bit          spurious = 1'b0;
  bit          spur_done = 1'b0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_ex_rdata = '0;
  int          if_acks = 0;
  int          ex_acks = 0;
  int          we_cycles = 0;
  bit          prev_ack = 1'b0;
  bit          if_ack_now = 1'b0;
  bit          ex_ack_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Drive each requester with its oldest pending queued transaction (or drop it).
  task automatic present();
    bit got_if = 1'b0;
    bit got_ex = 1'b0;
    bus.if_req = 1'b0;
    bus.ex_req = 1'b0;
    foreach (exp_q[i]) begin
      if (!exp_q[i].is_ex && !got_if) begin
        got_if      = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = exp_q[i].addr;
      end
      if (exp_q[i].is_ex && !got_ex) begin
        got_ex       = 1'b1;
        bus.ex_req   = 1'b1;
        bus.ex_we    = exp_q[i].we;
        bus.ex_addr  = exp_q[i].addr;
        bus.ex_wdata = exp_q[i].wdata;
      end
    end
  endtask

  task automatic push(input bit is_ex, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_ex = is_ex;
    t.we    = we;
    t.addr  = addr;
    t.wdata = is_ex ? wdata : 32'h0;
    t.rdata = (is_ex && we) ? 32'h0 : mem_arr[idx(addr)];
    exp_q.push_back(t);
    present();
  endtask

  // One clock: sample at the falling edge, score acks, then act as the memory.
  task automatic tick();
    txn_t e;
    @(negedge clk);
    if_ack_now = bus.if_ack;
    ex_ack_now = bus.ex_ack;
    if (if_ack_now) if_acks++;
    if (ex_ack_now) ex_acks++;
    if (bus.mem_req && bus.mem_we) we_cycles++;
    if (if_ack_now || ex_ack_now) begin
      check("ack_exclusive", {31'b0, if_ack_now & ex_ack_now}, 32'h0);
      check("ack_single_pulse", {31'b0, prev_ack}, 32'h0);
      check("ack_has_pending_txn", (exp_q.size() != 0) ? 32'h1 : 32'h0, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_owner_ex", {31'b0, ex_ack_now}, {31'b0, e.is_ex});
        if (!e.is_ex)          exp_if_rdata = e.rdata;
        if (e.is_ex && !e.we)  exp_ex_rdata = e.rdata;
        check("if_rdata_at_ack", bus.if_rdata, exp_if_rdata);
        check("ex_rdata_at_ack", bus.ex_rdata, exp_ex_rdata);
        $display("ack %s addr=%h we=%0d if_rdata=%h ex_rdata=%h", e.is_ex ? "EX" : "IF",
                 e.addr, e.we, bus.if_rdata, bus.ex_rdata);
        present();
      end
    end
    prev_ack      = if_ack_now | ex_ack_now;
    bus.mem_rdy   = spurious || (spur_done && prev_ack);
    bus.mem_rdata = 32'hBAD0_BAD0;
    if (bus.mem_req) begin
      if (rsp_cnt >= rsp_wait) begin
        rsp_cnt       = 0;
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = mem_arr[idx(bus.mem_addr)];
        if (bus.mem_we) mem_arr[idx(bus.mem_addr)] = bus.mem_wdata;
        check("mem_req_has_pending_txn", (exp_q.size() != 0) ? 32'h1 : 32'h0, 32'h1);
        if (exp_q.size() != 0) begin
          check("mem_addr", bus.mem_addr, exp_q[0].addr);
          check("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_q[0].we});
          check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
        end
      end else begin
        rsp_cnt++;
      end
    end else begin
      rsp_cnt = 0;
    end
  endtask

  task automatic wait_empty(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("queue_drained_in_budget", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  initial begin
    int ia, ea, if0, ex0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | 32'(i * 17);
    mem_arr[idx(32'h40)]  = 32'hDEAD_BEEF;
    mem_arr[idx(32'h100)] = 32'h5555_AAAA;

    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.ex_req   = 1'b1;
    bus.if_addr  = 32'h0;
    bus.ex_addr  = 32'h0;
    bus.ex_we    = 1'b0;
    bus.ex_wdata = 32'h0;
    bus.mem_rdy  = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset with both requests high: everything quiet.
    repeat (3) tick();
    check("rst_mem_req",   {31'b0, bus.mem_req}, 32'h0);
    check("rst_mem_we",    {31'b0, bus.mem_we},  32'h0);
    check("rst_mem_addr",  bus.mem_addr,  32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_if_ack",    {31'b0, bus.if_ack}, 32'h0);
    check("rst_ex_ack",    {31'b0, bus.ex_ack}, 32'h0);
    check("rst_if_rdata",  bus.if_rdata, 32'h0);
    check("rst_ex_rdata",  bus.ex_rdata, 32'h0);
    check("rst_busy",      {31'b0, bus.busy}, 32'h0);
    $display("reset: outputs checked");

    // Simultaneous requests out of reset: EX first, then IF.
    rsp_wait = 1;
    push(1'b1, 1'b0, 32'h80, 32'h0);
    push(1'b0, 1'b0, 32'h44, 32'h0);
    rst = 1'b0;
    wait_empty(50);

    // Lone IF read with same-cycle ready.
    rsp_wait = 0;
    push(1'b0, 1'b0, 32'h40, 32'h0);
    tick();
    check("t2_mem_req_cycle1",  {31'b0, bus.mem_req}, 32'h1);
    check("t2_mem_addr_cycle1", bus.mem_addr, 32'h40);
    tick();
    check("t2_if_ack_cycle2",   {31'b0, if_ack_now}, 32'h1);
    check("t2_if_rdata_cycle2", bus.if_rdata, 32'hDEAD_BEEF);
    tick();
    check("t2_busy_after", {31'b0, bus.busy}, 32'h0);

    // EX store with three wait states.
    rsp_wait  = 3;
    we_cycles = 0;
    ex0       = ex_acks;
    push(1'b1, 1'b1, 32'h100, 32'h1234);
    wait_empty(50);
    check("t3_we_held_cycles", 32'(we_cycles), 32'd4);
    check("t3_ex_ack_pulses",  32'(ex_acks - ex0), 32'd1);
    check("t3_ex_rdata_kept",  bus.ex_rdata, exp_ex_rdata);
    check("t3_mem_written",    mem_arr[idx(32'h100)], 32'h1234);

    // Both held continuously: EX,EX,EX,EX,IF twice.
    rsp_wait = 0;
    ia = 32'h300;
    ea = 32'h200;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push(1'b1, 1'b0, 32'(ea), 32'h0);
        ea += 4;
      end
      push(1'b0, 1'b0, 32'(ia), 32'h0);
      ia += 4;
    end
    wait_empty(200);

    // Spurious ready while idle.
    if0 = if_acks;
    ex0 = ex_acks;
    spurious = 1'b1;
    repeat (3) tick();
    spurious = 1'b0;
    check("t6_idle_busy",     {31'b0, bus.busy}, 32'h0);
    check("t6_idle_acks",     32'((if_acks - if0) + (ex_acks - ex0)), 32'h0);
    check("t6_idle_if_rdata", bus.if_rdata, exp_if_rdata);
    check("t6_idle_ex_rdata", bus.ex_rdata, exp_ex_rdata);

    // Spurious ready during DONE.
    spur_done = 1'b1;
    push(1'b0, 1'b0, 32'h48, 32'h0);
    wait_empty(50);
    tick();
    spur_done = 1'b0;
    check("t6_done_acks",     32'((if_acks - if0) + (ex_acks - ex0)), 32'h1);
    check("t6_done_if_rdata", bus.if_rdata, mem_arr[idx(32'h48)]);
    check("t6_done_busy",     {31'b0, bus.busy}, 32'h0);

    // Reset while EX is granted: transaction abandoned, no ack.
    rsp_wait    = 100;
    if0         = if_acks;
    ex0         = ex_acks;
    bus.ex_req  = 1'b1;
    bus.ex_we   = 1'b0;
    bus.ex_addr = 32'h204;
    tick();
    check("t1_gnt_busy",    {31'b0, bus.busy}, 32'h1);
    check("t1_gnt_mem_req", {31'b0, bus.mem_req}, 32'h1);
    rst        = 1'b1;
    bus.ex_req = 1'b0;
    tick();
    check("t1_rst_mem_req",  {31'b0, bus.mem_req}, 32'h0);
    check("t1_rst_busy",     {31'b0, bus.busy}, 32'h0);
    check("t1_rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    exp_if_rdata = 32'h0;
    exp_ex_rdata = 32'h0;
    repeat (4) tick();
    check("t1_no_ack_after_rst", 32'((if_acks - if0) + (ex_acks - ex0)), 32'h0);
    check("t1_if_rdata_cleared", bus.if_rdata, exp_if_rdata);
    check("t1_ex_rdata_cleared", bus.ex_rdata, exp_ex_rdata);
    $display("reset mid-transaction: checked");

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
